svga_timing: RTL and testbench
==============================

# svga_timing

Video timing generator for the SVGA output path. It runs free on the system clock and produces pixel coordinates, the blanking flag, and the sync strobes. Its `hsync`, `vsync`, `next_vertical` and `next_frame` outputs drive the pin mapping of the Tiny VGA PMOD and the bidir PMOD. `active_o` and the coordinate outputs feed the pixel/colour stage that produces `rrggbb`.

## Interface
- `H_ACTIVE`, 800: visible pixels per line
- `H_FRONT`, 40: horizontal front porch, in pixels
- `H_SYNC`, 128: hsync width, in pixels
- `H_BACK`, 88: horizontal back porch, in pixels
- `V_ACTIVE`, 600: visible lines per frame
- `V_FRONT`, 1: vertical front porch, in lines
- `V_SYNC`, 4: vsync width, in lines
- `V_BACK`, 23: vertical back porch, in lines
- `HSYNC_POL`, 1: level of `hsync_o` during the sync pulse
- `VSYNC_POL`, 1: level of `vsync_o` during the sync pulse
- Derived values: H_TOTAL = sum of the H_* parameters (default 1056); V_TOTAL = sum of the V_* parameters (default 628); HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL).
- `clk_i` input 1: pixel clock, 40 MHz for the default timing
- `rst_ni` input 1: reset. One clock; reset is asynchronous and active-low.
- `enable_i` input 1: run enable. While low, the block holds the idle state.
- `hcount_o` output HW: current pixel column, 0..H_TOTAL-1
- `vcount_o` output VW: current line, 0..V_TOTAL-1
- `active_o` output 1: high inside the visible area while running
- `hsync_o` output 1: horizontal sync
- `vsync_o` output 1: vertical sync
- `next_vertical_o` output 1: one-cycle pulse on the last pixel of every line
- `next_frame_o` output 1: one-cycle pulse on the last pixel of the frame

## Operation
- All outputs come straight from flops. There is no combinational path from any input to any output.
- Internal `running` flop:
  - set on every edge where `enable_i`=1
  - cleared on every edge where `enable_i`=0
- Counters:
  - On an edge with `running`=1 and `enable_i`=1, `hcount` increments.
  - At H_TOTAL-1, `hcount` wraps to 0 and `vcount` increments.
  - `vcount` wraps to 0 at V_TOTAL-1 when `hcount` also wraps.
  - On an edge with `enable_i`=0, both counters load 0.
- Output equations. Each output is registered so that it holds in the same cycle as the `hcount_o`/`vcount_o` values it refers to.
  - `active_o` = running & (hcount < H_ACTIVE) & (vcount < V_ACTIVE)
  - `hsync_o` = HSYNC_POL when running & H_ACTIVE+H_FRONT <= hcount < H_ACTIVE+H_FRONT+H_SYNC; otherwise ~HSYNC_POL
  - `vsync_o` = VSYNC_POL when running & V_ACTIVE+V_FRONT <= vcount < V_ACTIVE+V_FRONT+V_SYNC; otherwise ~VSYNC_POL. `vsync_o` changes only at line boundaries.
  - `next_vertical_o` = running & (hcount == H_TOTAL-1)
  - `next_frame_o` = running & (hcount == H_TOTAL-1) & (vcount == V_TOTAL-1). `next_vertical_o` is also high in that cycle.
- Reset and idle values:
  - `hcount_o`=0, `vcount_o`=0, `active_o`=0
  - `hsync_o`=~HSYNC_POL, `vsync_o`=~VSYNC_POL
  - `next_vertical_o`=0, `next_frame_o`=0
- There are no parameter checks at runtime. Every parameter must be >= 1.

## Timing
- Start:
  - Edge E0 samples `enable_i`=1 from idle. After E0: `running`=1, coordinates (0,0), `active_o`=1.
  - After E0+n, `hcount_o`=n mod H_TOTAL.
- Line period is H_TOTAL cycles; frame period is H_TOTAL*V_TOTAL cycles (663168 at default).
- Default hsync: high for hcount 840..967. Default vsync: high for vcount 601..604.
- `next_vertical_o` fires V_TOTAL times per frame, one cycle wide, in the cycle before the coordinates advance to the next line.
- `next_frame_o` fires in the cycle before coordinates (0,0).
- Disable mid-frame: the edge that samples `enable_i`=0 produces the idle values. No partial pulse is stretched. A new start then follows the Start rule.
- Reset mid-frame: asserting `rst_ni` drives the idle values asynchronously. After deassertion the block follows the Start rule.
- Back-to-back frames have no gap: (H_TOTAL-1, V_TOTAL-1) is followed directly by (0,0).

## Test plan
- Reset and idle:
  - Stimulus: assert `rst_ni`=0 mid-frame.
  - Required: outputs take the idle values immediately (hsync 0, vsync 0 at default polarity).
  - Stimulus: hold `enable_i`=0 for 100 cycles.
  - Required: outputs stay idle.
- Line timing, default parameters:
  - Stimulus: run one full line after start.
  - Required: `active_o` high for exactly 800 cycles. `hsync_o` rises when `hcount_o`=840 and falls when `hcount_o`=968. `next_vertical_o` is high only at `hcount_o`=1055.
- Frame timing with small parameters (H 4/1/2/1, V 3/1/1/1, so H_TOTAL=8 and V_TOTAL=6), over 3 frames:
  - `vsync_o` high only while `vcount_o`=4.
  - `next_vertical_o` pulses 18 times.
  - `next_frame_o` pulses every 48 cycles, coinciding with (7,5).
- Polarity:
  - Stimulus: HSYNC_POL=0, VSYNC_POL=0.
  - Required: both syncs idle high and pulse low at the same positions as the line and frame tests.
- Enable toggle:
  - Stimulus: drop `enable_i` at `hcount_o`=1055 of the last line.
  - Required: `next_frame_o` is not extended, and coordinates return to (0,0).
  - Stimulus: re-raise `enable_i`.
  - Required: `active_o`=1 one edge later.
- Pulse exclusivity: over a full default frame, `next_frame_o` is asserted exactly once and only while `next_vertical_o`=1.

Source files
------------

// File: rtl/svga_timing.sv
// Free-running SVGA timing generator: pixel/line counters, visible-area flag,
// sync strobes and end-of-line / end-of-frame pulses, all driven from flops.
module svga_timing #(
    parameter int H_ACTIVE  = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_ACTIVE  = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1,
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enable_i,
    output logic [HW-1:0] hcount_o,
    output logic [VW-1:0] vcount_o,
    output logic          active_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          next_vertical_o,
    output logic          next_frame_o
);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    logic          running;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          h_in_sync;
    logic          v_in_sync;

    // The first enabled edge only sets running; counting starts on the next one,
    // so the start edge lands on (0,0).
    always_comb begin
        h_nxt = hcount_o;
        v_nxt = vcount_o;
        if (!enable_i) begin
            h_nxt = '0;
            v_nxt = '0;
        end else if (running) begin
            if (hcount_o == H_LAST) begin
                h_nxt = '0;
                v_nxt = (vcount_o == V_LAST) ? '0 : vcount_o + VW'(1);
            end else begin
                h_nxt = hcount_o + HW'(1);
            end
        end
    end

    // Output flops are decoded from the next-state coordinates so they line up
    // with the registered counter values they describe.
    assign h_in_sync = (h_nxt >= HS_START) && (h_nxt < HS_END);
    assign v_in_sync = (v_nxt >= VS_START) && (v_nxt < VS_END);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            running         <= 1'b0;
            hcount_o        <= '0;
            vcount_o        <= '0;
            active_o        <= 1'b0;
            hsync_o         <= ~HSYNC_POL;
            vsync_o         <= ~VSYNC_POL;
            next_vertical_o <= 1'b0;
            next_frame_o    <= 1'b0;
        end else begin
            running         <= enable_i;
            hcount_o        <= h_nxt;
            vcount_o        <= v_nxt;
            active_o        <= enable_i && (h_nxt < H_VIS) && (v_nxt < V_VIS);
            hsync_o         <= (enable_i && h_in_sync) ? HSYNC_POL : ~HSYNC_POL;
            vsync_o         <= (enable_i && v_in_sync) ? VSYNC_POL : ~VSYNC_POL;
            next_vertical_o <= enable_i && (h_nxt == H_LAST);
            next_frame_o    <= enable_i && (h_nxt == H_LAST) && (v_nxt == V_LAST);
        end
    end

endmodule

// File: tb/tb_svga_timing.sv
// Bench for svga_timing: default, inverted-polarity and small-geometry instances
// share clock, reset and enable; expectations come from tables and closed-form timing.
module tb_svga_timing;

    logic clk;
    logic rst_n;
    logic en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] d_h, dp_h;
    logic [9:0]  d_v, dp_v;
    logic        d_act, d_hs, d_vs, d_nv, d_nf;
    logic        dp_act, dp_hs, dp_vs, dp_nv, dp_nf;
    logic [2:0]  s_h, s_v, p_h, p_v;
    logic        s_act, s_hs, s_vs, s_nv, s_nf;
    logic        p_act, p_hs, p_vs, p_nv, p_nf;

    svga_timing dut_d (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
        .hcount_o(d_h), .vcount_o(d_v), .active_o(d_act), .hsync_o(d_hs),
        .vsync_o(d_vs), .next_vertical_o(d_nv), .next_frame_o(d_nf)
    );

    svga_timing #(.HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) dut_dp (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
        .hcount_o(dp_h), .vcount_o(dp_v), .active_o(dp_act), .hsync_o(dp_hs),
        .vsync_o(dp_vs), .next_vertical_o(dp_nv), .next_frame_o(dp_nf)
    );

    svga_timing #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                  .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
        .hcount_o(s_h), .vcount_o(s_v), .active_o(s_act), .hsync_o(s_hs),
        .vsync_o(s_vs), .next_vertical_o(s_nv), .next_frame_o(s_nf)
    );

    svga_timing #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                  .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                  .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) dut_p (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
        .hcount_o(p_h), .vcount_o(p_v), .active_o(p_act), .hsync_o(p_hs),
        .vsync_o(p_vs), .next_vertical_o(p_nv), .next_frame_o(p_nf)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_d_idle(input string tag);
        chk({tag, "_d_h"}, d_h, 0);
        chk({tag, "_d_v"}, d_v, 0);
        chk({tag, "_d_act"}, d_act, 0);
        chk({tag, "_d_hs"}, d_hs, 0);
        chk({tag, "_d_vs"}, d_vs, 0);
        chk({tag, "_d_nv"}, d_nv, 0);
        chk({tag, "_d_nf"}, d_nf, 0);
        chk({tag, "_dp_hs"}, dp_hs, 1);
        chk({tag, "_dp_vs"}, dp_vs, 1);
    endtask

    typedef struct {
        logic en;
        int   cycles;
        int   h;
        int   v;
        logic act;
        logic hs;
        logic vs;
        logic nv;
        logic nf;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int idle_bad;
        int d_bad, dp_bad;
        int act_cnt, nv_cnt, nv_pos;
        int hs_rise, hs_fall, dp_low_start, dp_low_end;
        logic prev_hs, prev_dphs;
        int s_nv_cnt, s_nf_cnt, s_nf_bad, excl_bad;
        int eh, ev;
        logic eact, ehs, evs, env, enf;

        //            en  cyc  h  v  act hs vs nv nf
        tbl[0]  = '{1'b1,  1, 0, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{1'b1,  4, 4, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1'b1,  1, 5, 0, 0, 1, 0, 0, 0};
        tbl[3]  = '{1'b1,  2, 7, 0, 0, 0, 0, 1, 0};
        tbl[4]  = '{1'b1,  1, 0, 1, 1, 0, 0, 0, 0};
        tbl[5]  = '{1'b1, 24, 0, 4, 0, 0, 1, 0, 0};
        tbl[6]  = '{1'b1,  5, 5, 4, 0, 1, 1, 0, 0};
        tbl[7]  = '{1'b1,  2, 7, 4, 0, 0, 1, 1, 0};
        tbl[8]  = '{1'b1,  8, 7, 5, 0, 0, 0, 1, 1};
        tbl[9]  = '{1'b0,  1, 0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{1'b0,  5, 0, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{1'b1,  1, 0, 0, 1, 0, 0, 0, 0};
        tbl[12] = '{1'b1, 47, 7, 5, 0, 0, 0, 1, 1};
        tbl[13] = '{1'b1,  1, 0, 0, 1, 0, 0, 0, 0};
        tbl[14] = '{1'b1, 19, 3, 2, 1, 0, 0, 0, 0};
        tbl[15] = '{1'b0,  1, 0, 0, 0, 0, 0, 0, 0};

        // Reset and idle
        rst_n = 1'b0;
        en    = 1'b0;
        #17;
        chk_d_idle("reset");
        step();
        rst_n = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (d_h !== 0 || d_v !== 0 || d_act !== 0 || d_hs !== 0 || d_vs !== 0 ||
                d_nv !== 0 || d_nf !== 0 || dp_hs !== 1 || dp_vs !== 1 ||
                s_act !== 0 || s_nv !== 0 || p_hs !== 1 || p_vs !== 1)
                idle_bad++;
        end
        chk("idle_100_bad_cycles", idle_bad, 0);

        // Start, then one default line while the small instances run three frames
        en = 1'b1;
        d_bad = 0; dp_bad = 0; act_cnt = 0; nv_cnt = 0; nv_pos = -1;
        hs_rise = -1; hs_fall = -1; dp_low_start = -1; dp_low_end = -1;
        prev_hs = 1'b0; prev_dphs = 1'b1;
        s_nv_cnt = 0; s_nf_cnt = 0; s_nf_bad = 0; excl_bad = 0;
        for (int n = 0; n < 1056; n++) begin
            step();
            if (n == 0) begin
                chk("start_d_h", d_h, 0);
                chk("start_d_v", d_v, 0);
                chk("start_d_act", d_act, 1);
            end
            if (d_h !== n || d_v !== 0 || d_vs !== 0 || d_nf !== 0 ||
                d_act !== (n < 800) || d_hs !== (n >= 840 && n < 968) || d_nv !== (n == 1055))
                d_bad++;
            if (dp_h !== n || dp_v !== 0 || dp_vs !== 1 || dp_nf !== 0 ||
                dp_act !== (n < 800) || dp_hs !== !(n >= 840 && n < 968) || dp_nv !== (n == 1055))
                dp_bad++;
            if (d_act === 1'b1) act_cnt++;
            if (d_nv === 1'b1) begin nv_cnt++; nv_pos = int'(d_h); end
            if (d_hs === 1'b1 && prev_hs === 1'b0 && hs_rise < 0) hs_rise = int'(d_h);
            if (d_hs === 1'b0 && prev_hs === 1'b1 && hs_fall < 0) hs_fall = int'(d_h);
            if (dp_hs === 1'b0 && prev_dphs === 1'b1 && dp_low_start < 0) dp_low_start = int'(dp_h);
            if (dp_hs === 1'b1 && prev_dphs === 1'b0 && dp_low_end < 0) dp_low_end = int'(dp_h);
            prev_hs = d_hs;
            prev_dphs = dp_hs;
            if (d_nf === 1'b1 && d_nv !== 1'b1) excl_bad++;

            if (n < 144) begin
                eh   = n % 8;
                ev   = (n / 8) % 6;
                eact = (eh < 4) && (ev < 3);
                ehs  = (eh >= 5) && (eh < 7);
                evs  = (ev == 4);
                env  = (eh == 7);
                enf  = (eh == 7) && (ev == 5);
                chk("frm_s_h", s_h, eh);
                chk("frm_s_v", s_v, ev);
                chk("frm_s_act", s_act, eact);
                chk("frm_s_hs", s_hs, ehs);
                chk("frm_s_vs", s_vs, evs);
                chk("frm_s_nv", s_nv, env);
                chk("frm_s_nf", s_nf, enf);
                chk("frm_p_hs", p_hs, !ehs);
                chk("frm_p_vs", p_vs, !evs);
                chk("frm_p_hv", {p_h, p_v, p_act, p_nv, p_nf}, {eh[2:0], ev[2:0], eact, env, enf});
                if (s_nv === 1'b1) s_nv_cnt++;
                if (s_nf === 1'b1) begin
                    s_nf_cnt++;
                    if ((n % 48) != 47) s_nf_bad++;
                end
                if (s_nf === 1'b1 && s_nv !== 1'b1) excl_bad++;
            end
        end
        chk("line_d_bad_cycles", d_bad, 0);
        chk("line_dp_bad_cycles", dp_bad, 0);
        chk("line_active_count", act_cnt, 800);
        chk("line_hsync_rise_h", hs_rise, 840);
        chk("line_hsync_fall_h", hs_fall, 968);
        chk("line_dp_hsync_low_h", dp_low_start, 840);
        chk("line_dp_hsync_high_h", dp_low_end, 968);
        chk("line_nv_count", nv_cnt, 1);
        chk("line_nv_h", nv_pos, 1055);
        chk("frm_nv_count", s_nv_cnt, 18);
        chk("frm_nf_count", s_nf_cnt, 3);
        chk("frm_nf_misplaced", s_nf_bad, 0);
        chk("pulse_exclusivity", excl_bad, 0);

        // Drop enable on the last pixel of the line, then re-raise
        en = 1'b0;
        step();
        chk_d_idle("drop");
        en = 1'b1;
        step();
        chk("restart_d_act", d_act, 1);
        chk("restart_d_h", d_h, 0);
        en = 1'b0;
        step();
        step();

        // Small-geometry table: same vector checks both polarities
        foreach (tbl[i]) begin
            en = tbl[i].en;
            repeat (tbl[i].cycles) step();
            chk($sformatf("tbl%0d_s_h", i), s_h, tbl[i].h);
            chk($sformatf("tbl%0d_s_v", i), s_v, tbl[i].v);
            chk($sformatf("tbl%0d_s_act", i), s_act, tbl[i].act);
            chk($sformatf("tbl%0d_s_hs", i), s_hs, tbl[i].hs);
            chk($sformatf("tbl%0d_s_vs", i), s_vs, tbl[i].vs);
            chk($sformatf("tbl%0d_s_nv", i), s_nv, tbl[i].nv);
            chk($sformatf("tbl%0d_s_nf", i), s_nf, tbl[i].nf);
            chk($sformatf("tbl%0d_p_hs", i), p_hs, !tbl[i].hs);
            chk($sformatf("tbl%0d_p_vs", i), p_vs, !tbl[i].vs);
        end

        // Asynchronous reset in the middle of the default hsync pulse
        en = 1'b1;
        step();
        repeat (900) step();
        chk("pre_reset_d_h", d_h, 900);
        chk("pre_reset_d_hs", d_hs, 1);
        chk("pre_reset_dp_hs", dp_hs, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_d_idle("async_reset");
        step();
        chk_d_idle("held_reset");
        rst_n = 1'b1;
        step();
        chk("post_reset_d_h", d_h, 0);
        chk("post_reset_d_act", d_act, 1);
        step();
        chk("post_reset_d_h1", d_h, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
